sipo_collector: RTL

Serial-in/parallel-out collector: accepts a stream of `SHIFT_AMOUNT`-bit words under a valid/ready handshake and assembles them into one `PARALLEL_DATA_BITS` block. It is the receive-side counterpart of the keystream serializer. It gathers plaintext/ciphertext words into 512-bit blocks for the ChaCha20 XOR stage and supports a short final block.

---
 rtl/sipo_collector_pkg.sv | 23 ++
 rtl/sipo_collector.sv | 96 +++++++++
 2 files changed

// File: rtl/sipo_collector_pkg.sv
// Shared stream package: FILL/FULL state encoding and the derived word-count helpers
// used by the serial/parallel stream blocks.
package sipo_collector_pkg;

    typedef enum logic {
        StFill = 1'b0,
        StFull = 1'b1
    } sipo_state_e;

    localparam int unsigned DEFAULT_PARALLEL_DATA_BITS = 16 * 32;
    localparam int unsigned DEFAULT_SHIFT_AMOUNT       = 8;

    function automatic int unsigned sipo_num_words(input int unsigned pbits,
                                                   input int unsigned shift);
        return pbits / shift;
    endfunction

    // Counter must hold NUM_WORDS itself, not just NUM_WORDS-1.
    function automatic int unsigned sipo_cnt_width(input int unsigned num_words);
        return $clog2(num_words + 1);
    endfunction

endpackage

// File: rtl/sipo_collector.sv
// Serial-in/parallel-out collector: gathers SHIFT_AMOUNT-bit words into one block,
// with early completion on serial_last_i for a short final block.
module sipo_collector
    import sipo_collector_pkg::*;
#(
    parameter int unsigned PARALLEL_DATA_BITS = DEFAULT_PARALLEL_DATA_BITS,
    parameter int unsigned SHIFT_AMOUNT       = DEFAULT_SHIFT_AMOUNT,
    parameter string       DIRECTION          = "RIGHT"
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic [SHIFT_AMOUNT-1:0]                                serial_i,
    input  logic                                                   serial_valid_i,
    input  logic                                                   serial_last_i,
    output logic                                                   serial_ready_o,
    output logic [PARALLEL_DATA_BITS-1:0]                          parallel_o,
    output logic                                                   parallel_valid_o,
    output logic                                                   parallel_last_o,
    output logic [$clog2(PARALLEL_DATA_BITS/SHIFT_AMOUNT+1)-1:0]   parallel_words_o,
    input  logic                                                   parallel_ready_i
);

    localparam int unsigned       NUM_WORDS = sipo_num_words(PARALLEL_DATA_BITS, SHIFT_AMOUNT);
    localparam int unsigned       CNT_W     = sipo_cnt_width(NUM_WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam bit                FILL_LEFT = (DIRECTION == "LEFT");

    sipo_state_e                   r_state, w_state_d;
    logic [CNT_W-1:0]              r_count, w_count_d;
    logic [CNT_W-1:0]              r_words, w_words_d;
    logic [PARALLEL_DATA_BITS-1:0] r_data, w_data_d;
    logic                          r_last, w_last_d;
    logic [CNT_W-1:0]              w_slice;
    logic                          w_accept;

    assign w_accept = serial_valid_i && (r_state == StFill);
    assign w_slice  = FILL_LEFT ? (LAST_IDX - r_count) : r_count;

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_words_d = r_words;
        w_data_d  = r_data;
        w_last_d  = r_last;
        unique case (r_state)
            StFill: begin
                if (w_accept) begin
                    // Indexed write: slices not yet reached stay zero for short blocks.
                    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                        if (w_slice == CNT_W'(k)) begin
                            w_data_d[k*SHIFT_AMOUNT +: SHIFT_AMOUNT] = serial_i;
                        end
                    end
                    w_count_d = r_count + CNT_W'(1);
                    if ((r_count == LAST_IDX) || serial_last_i) begin
                        w_state_d = StFull;
                        w_words_d = r_count + CNT_W'(1);
                        w_last_d  = serial_last_i;
                    end
                end
            end
            StFull: begin
                if (parallel_ready_i) begin
                    w_state_d = StFill;
                    w_count_d = '0;
                    w_data_d  = '0;
                    w_last_d  = 1'b0;
                end
            end
            default: w_state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StFill;
            r_count <= '0;
            r_words <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_words <= w_words_d;
            r_data  <= w_data_d;
            r_last  <= w_last_d;
        end
    end

    assign serial_ready_o   = (r_state == StFill);
    assign parallel_valid_o = (r_state == StFull);
    assign parallel_o       = r_data;
    assign parallel_last_o  = r_last;
    assign parallel_words_o = r_words;

endmodule
